// File: rtl/card_grid_renderer_if.sv
// Command port between the game controller and the card grid renderer.
//   cmd_valid  controller has a command
//   cmd_ready  renderer can take it (low while a flip animates)
//   cmd_op     00 FLIP_UP, 01 FLIP_DOWN, 10 MATCH, 11 SET_FACE
//   cmd_idx    target card, row-major
//   cmd_face   face index used by SET_FACE
interface card_grid_renderer_if #(
  parameter int IDX_W  = 4,
  parameter int FACE_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_idx;
  logic [FACE_W-1:0] cmd_face;

  modport master (output cmd_valid, cmd_op, cmd_idx, cmd_face, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_idx, cmd_face, output cmd_ready);
endinterface

// File: rtl/card_grid_renderer.sv
// Memory-game board renderer: ROWS x COLS image cards on the 640x480 raster
// with per-card state (down/up/matched), face index and an animated flip.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   HCount, VCount      current raster position
//   frame_tick          one pulse per frame, advances the flip animation
//   cmd                 command port (slave side)
//   busy                flip animation in progress
//   rom_face, rom_row   card ROM address (data returns one clock later)
//   rom_data            one ROM row, pixel c at [3c+2:3c]
//   cardon, rgb         coverage and colour, 3 clocks after HCount/VCount
module card_grid_renderer #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int ORIGIN_X    = 130,
  parameter int ORIGIN_Y    = 70,
  parameter int PITCH_X     = 100,
  parameter int PITCH_Y     = 100,
  parameter int CARD_W      = 90,
  parameter int CARD_H      = 90,
  parameter int FACE_W      = 3,
  parameter int ANIM_FRAMES = 8,
  parameter int INSET_STEP  = 10,
  parameter int BORDER      = 3,
  parameter int IDX_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            HCount,
  input  logic [9:0]            VCount,
  input  logic                  frame_tick,
  card_grid_renderer_if.slave   cmd,
  output logic                  busy,
  output logic [FACE_W-1:0]     rom_face,
  output logic [6:0]            rom_row,
  input  logic [3*CARD_W-1:0]   rom_data,
  output logic                  cardon,
  output logic [2:0]            rgb
);
  localparam int NCARDS = ROWS * COLS;
  localparam int HALF   = ANIM_FRAMES / 2;
  localparam int LAST   = ANIM_FRAMES - 1;
  localparam int PH_W   = $clog2(ANIM_FRAMES);

  typedef enum logic [1:0] {CS_DOWN, CS_UP, CS_MATCHED} card_st_e;
  typedef enum logic {A_IDLE, A_FLIP} anim_e;

  anim_e             anim_q, anim_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [IDX_W-1:0]  aidx_q, aidx_d;
  logic              aup_q, aup_d;
  card_st_e          cst_q [NCARDS];
  card_st_e          cst_d [NCARDS];
  logic [FACE_W-1:0] face_q [NCARDS];
  logic [FACE_W-1:0] face_d [NCARDS];

  function automatic logic [2:0] pick_rgb(input card_st_e side, input logic border,
                                          input logic [2:0] px);
    case (side)
      CS_DOWN:    return 3'b100;
      CS_MATCHED: return border ? 3'b010 : px;
      default:    return px;
    endcase
  endfunction

  assign busy          = (anim_q == A_FLIP);
  assign cmd.cmd_ready = !busy;

  // Command decode and animation sequencing
  always_comb begin
    anim_d  = anim_q;
    phase_d = phase_q;
    aidx_d  = aidx_q;
    aup_d   = aup_q;
    cst_d   = cst_q;
    face_d  = face_q;
    case (anim_q)
      A_IDLE: begin
        if (cmd.cmd_valid && int'(cmd.cmd_idx) < NCARDS) begin
          case (cmd.cmd_op)
            2'b00: if (cst_q[cmd.cmd_idx] == CS_DOWN) begin
              anim_d = A_FLIP; phase_d = '0; aidx_d = cmd.cmd_idx; aup_d = 1'b1;
            end
            2'b01: if (cst_q[cmd.cmd_idx] == CS_UP) begin
              anim_d = A_FLIP; phase_d = '0; aidx_d = cmd.cmd_idx; aup_d = 1'b0;
            end
            2'b10:   cst_d[cmd.cmd_idx]  = CS_MATCHED;
            default: face_d[cmd.cmd_idx] = cmd.cmd_face;
          endcase
        end
      end
      default: begin
        if (frame_tick) begin
          if (phase_q == PH_W'(LAST)) begin
            // The card only changes state once the whole flip has been shown.
            cst_d[aidx_q] = aup_q ? CS_UP : CS_DOWN;
            anim_d        = A_IDLE;
            phase_d       = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_q  <= A_IDLE;
      phase_q <= '0;
      aidx_q  <= '0;
      aup_q   <= 1'b0;
      for (int i = 0; i < NCARDS; i++) begin
        cst_q[i]  <= CS_DOWN;
        face_q[i] <= '0;
      end
    end else begin
      anim_q  <= anim_d;
      phase_q <= phase_d;
      aidx_q  <= aidx_d;
      aup_q   <= aup_d;
      cst_q   <= cst_d;
      face_q  <= face_d;
    end
  end

  // Hit test by per-column and per-row range compares
  logic             col_hit, row_hit, hit_c, vis_c, border_c;
  int               col_sel, row_sel, inset, mirror;
  logic [9:0]       lcol_c;
  logic [6:0]       lrow_c;
  logic [IDX_W-1:0] idx_c;
  card_st_e         side_c;

  always_comb begin
    col_hit = 1'b0; row_hit = 1'b0; col_sel = 0; row_sel = 0;
    lcol_c  = '0;   lrow_c  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (int'(HCount) >= ORIGIN_X + c*PITCH_X && int'(HCount) < ORIGIN_X + c*PITCH_X + CARD_W) begin
        col_hit = 1'b1; col_sel = c;
        lcol_c  = 10'(int'(HCount) - ORIGIN_X - c*PITCH_X);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (int'(VCount) >= ORIGIN_Y + r*PITCH_Y && int'(VCount) < ORIGIN_Y + r*PITCH_Y + CARD_H) begin
        row_hit = 1'b1; row_sel = r;
        lrow_c  = 7'(int'(VCount) - ORIGIN_Y - r*PITCH_Y);
      end
    end
    hit_c  = col_hit && row_hit;
    idx_c  = IDX_W'(row_sel*COLS + col_sel);
    side_c = cst_q[idx_c];
    inset  = 0;
    mirror = 0;
    if (busy && idx_c == aidx_q) begin
      // Card narrows towards the middle of the flip and widens again after.
      mirror = (int'(phase_q) < HALF) ? int'(phase_q) : LAST - int'(phase_q);
      inset  = INSET_STEP * mirror;
      if (int'(phase_q) >= HALF) side_c = aup_q ? CS_UP : CS_DOWN;
    end
    vis_c    = hit_c && int'(lcol_c) >= inset && int'(lcol_c) < CARD_W - inset;
    border_c = int'(lcol_c) < BORDER || int'(lcol_c) >= CARD_W - BORDER ||
               int'(lrow_c) < BORDER || int'(lrow_c) >= CARD_H - BORDER;
  end

  logic       vis_p1_q, vis_p2_q, border_p1_q, border_p2_q;
  card_st_e   side_p1_q, side_p2_q;
  logic [9:0] lcol_p1_q, lcol_p2_q;
  logic [2:0] rom_px_c, rgb_d;

  always_comb begin
    rom_px_c = '0;
    if (vis_p2_q) rom_px_c = rom_data[3*int'(lcol_p2_q) +: 3];
    rgb_d = vis_p2_q ? pick_rgb(side_p2_q, border_p2_q, rom_px_c) : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_p1_q <= 1'b0;
      vis_p2_q <= 1'b0;
      rom_face <= '0;
      rom_row  <= '0;
      cardon   <= 1'b0;
      rgb      <= 3'b000;
    end else begin
      // Stage 1: pixel sampled, card state and inset frozen, ROM addressed
      vis_p1_q <= vis_c;
      rom_face <= hit_c ? face_q[idx_c] : '0;
      rom_row  <= hit_c ? lrow_c : '0;
      // Stage 2: ROM row being read
      vis_p2_q <= vis_p1_q;
      // Stage 3: final colour
      cardon   <= vis_p2_q;
      rgb      <= rgb_d;
    end
  end

  always_ff @(posedge clk) begin
    side_p1_q   <= side_c;
    border_p1_q <= border_c;
    lcol_p1_q   <= lcol_c;
    side_p2_q   <= side_p1_q;
    border_p2_q <= border_p1_q;
    lcol_p2_q   <= lcol_p1_q;
  end
endmodule

// File: tb/tb_card_grid_renderer.sv
module tb_card_grid_renderer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [9:0]   HCount = '0, VCount = '0;
  logic         frame_tick = 1'b0;
  logic         busy, cardon;
  logic [2:0]   rom_face, rgb;
  logic [6:0]   rom_row;
  logic [269:0] rom_data = '0;

  card_grid_renderer_if #(.IDX_W(4), .FACE_W(3)) cif ();

  card_grid_renderer dut (
    .clk(clk), .rst_n(rst_n), .HCount(HCount), .VCount(VCount),
    .frame_tick(frame_tick), .cmd(cif), .busy(busy), .rom_face(rom_face),
    .rom_row(rom_row), .rom_data(rom_data), .cardon(cardon), .rgb(rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_px(int f, int r, int c);
    return 3'((f*5 + r*3 + c) % 8);
  endfunction

  function automatic logic [269:0] rom_line(int f, int r);
    logic [269:0] v;
    v = '0;
    for (int c = 0; c < 90; c++) v[3*c +: 3] = rom_px(f, r, c);
    return v;
  endfunction

  always @(posedge clk) rom_data <= rom_line(int'(rom_face), int'(rom_row));

  int total = 0, bad = 0;

  // Reference card model (0 DOWN, 1 UP, 2 MATCHED)
  int m_state [16];
  int m_face  [16];
  int m_busy = 0, m_phase = 0, m_aidx = 0, m_up = 0;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin m_state[i] = 0; m_face[i] = 0; end
    m_busy = 0; m_phase = 0;
  endtask

  task automatic m_accept(int op, int idx, int face);
    case (op)
      0: if (m_state[idx] == 0) begin m_busy = 1; m_phase = 0; m_aidx = idx; m_up = 1; end
      1: if (m_state[idx] == 1) begin m_busy = 1; m_phase = 0; m_aidx = idx; m_up = 0; end
      2: m_state[idx] = 2;
      default: m_face[idx] = face;
    endcase
  endtask

  task automatic m_tick();
    if (m_busy != 0) begin
      if (m_phase == 7) begin
        m_state[m_aidx] = (m_up != 0) ? 1 : 0;
        m_busy = 0; m_phase = 0;
      end else m_phase++;
    end
  endtask

  function automatic logic [3:0] exp_pix(int x, int y);
    int lc, lr, idx, side, inset, ph;
    bit hit;
    hit = 0; lc = 0; lr = 0; idx = 0; inset = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (x >= 130 + c*100 && x <= 219 + c*100 && y >= 70 + r*100 && y <= 159 + r*100) begin
          hit = 1; lc = x - 130 - c*100; lr = y - 70 - r*100; idx = r*4 + c;
        end
    if (!hit) return 4'b0000;
    side = m_state[idx];
    if (m_busy != 0 && idx == m_aidx) begin
      ph    = m_phase;
      inset = 10 * ((ph < 7 - ph) ? ph : 7 - ph);
      if (ph >= 4) side = (m_up != 0) ? 1 : 0;
    end
    if (lc < inset || lc >= 90 - inset) return 4'b0000;
    if (side == 0) return 4'b1100;
    if (side == 2 && (lc < 3 || lc >= 87 || lr < 3 || lr >= 87)) return 4'b1010;
    return {1'b1, rom_px(m_face[idx], lr, lc)};
  endfunction

  // Scoreboard: expected pixel pushed when driven, popped 3 clocks later
  typedef struct { int x; int y; logic [3:0] e; } exp_t;
  exp_t       exp_q[$];
  logic       tag = 1'b0;
  logic [2:0] tagd = 3'b000;

  always @(posedge clk) tagd <= {tagd[1:0], tag};

  always @(negedge clk) begin
    if (tagd[2]) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pix_unexpected got on=%0b rgb=%03b want no output", cardon, rgb);
      end else begin
        exp_t t;
        t = exp_q.pop_front();
        if ({cardon, rgb} !== t.e) begin
          bad++;
          $display("FAIL pix(%0d,%0d) got on=%0b rgb=%03b want on=%0b rgb=%03b",
                   t.x, t.y, cardon, rgb, t.e[3], t.e[2:0]);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(int x, int y, logic [3:0] e);
    exp_t t;
    t.x = x; t.y = y; t.e = e;
    HCount = 10'(x); VCount = 10'(y); tag = 1'b1;
    exp_q.push_back(t);
    tick_clk();
    tag = 1'b0;
  endtask

  task automatic push_model(int x, int y);
    push_exp(x, y, exp_pix(x, y));
  endtask

  task automatic drain();
    HCount = '0; VCount = '0;
    repeat (4) tick_clk();
  endtask

  task automatic send_cmd(int op, int idx, int face);
    int n;
    n = 0;
    cif.cmd_valid = 1'b1; cif.cmd_op = 2'(op); cif.cmd_idx = 4'(idx); cif.cmd_face = 3'(face);
    forever begin
      @(negedge clk);
      if (cif.cmd_ready) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL cmd_timeout got ready=0 want ready=1 within 50 clocks");
        break;
      end
    end
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    if (n <= 50) m_accept(op, idx, face);
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
    m_tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  int xs[12] = '{129, 130, 219, 220, 229, 230, 319, 320, 330, 519, 520, 639};
  int ys[8]  = '{69, 70, 159, 160, 170, 459, 460, 479};
  int cols5[7] = '{0, 29, 30, 45, 59, 60, 89};

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_idx = '0; cif.cmd_face = '0;
    m_reset();
    #12;
    chk("rst_cardon", 32'(cardon), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_rom_face", 32'(rom_face), 0);
    chk("rst_rom_row", 32'(rom_row), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cif.cmd_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    tick_clk();

    // Grid scan at card edges and gaps: all cards face down
    foreach (ys[j]) foreach (xs[i]) push_model(xs[i], ys[j]);
    push_exp(175, 115, 4'b1100);
    push_exp(225, 115, 4'b0000);
    drain();

    // Flip card 5 up with face 3
    send_cmd(3, 5, 3);
    send_cmd(0, 5, 0);
    chk("busy_start", 32'(busy), 1);
    chk("ready_start", 32'(cif.cmd_ready), 0);
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      chk($sformatf("busy_ph%0d", k), 32'(busy), 1);
    end
    push_exp(259, 180, 4'b0000);
    push_exp(260, 180, 4'b1100);
    push_exp(289, 180, 4'b1100);
    push_exp(290, 180, 4'b0000);
    foreach (cols5[i]) push_model(230 + cols5[i], 200);
    drain();
    do_tick();
    chk("busy_ph4", 32'(busy), 1);
    push_exp(259, 180, 4'b0000);
    push_exp(260, 180, {1'b1, rom_px(3, 10, 30)});
    push_exp(289, 180, {1'b1, rom_px(3, 10, 59)});
    push_exp(290, 180, 4'b0000);
    drain();
    for (int k = 5; k <= 7; k++) begin
      do_tick();
      chk($sformatf("busy_ph%0d", k), 32'(busy), 1);
    end

    // Command held through the final tick: refused, then taken next clock
    cif.cmd_valid = 1'b1; cif.cmd_op = 2'd0; cif.cmd_idx = 4'd6; cif.cmd_face = '0;
    @(negedge clk);
    chk("ready_while_busy", 32'(cif.cmd_ready), 0);
    tick_clk();
    push_model(375, 215);
    drain();
    frame_tick = 1'b1;
    @(negedge clk);
    chk("ready_final_tick", 32'(cif.cmd_ready), 0);
    tick_clk();
    frame_tick = 1'b0;
    m_tick();
    chk("busy_after_flip", 32'(busy), 0);
    chk("ready_after_flip", 32'(cif.cmd_ready), 1);
    tick_clk();
    cif.cmd_valid = 1'b0;
    m_accept(0, 6, 0);
    chk("busy_second_flip", 32'(busy), 1);
    push_exp(230, 180, {1'b1, rom_px(3, 10, 0)});
    push_exp(319, 180, {1'b1, rom_px(3, 10, 89)});
    push_exp(275, 215, {1'b1, rom_px(3, 45, 45)});
    foreach (cols5[i]) push_model(230 + cols5[i], 250);
    drain();

    // Card 6 to phase 2, then reset mid-animation
    do_tick();
    do_tick();
    push_exp(349, 180, 4'b0000);
    push_exp(350, 180, 4'b1100);
    push_exp(399, 180, 4'b1100);
    push_exp(400, 180, 4'b0000);
    drain();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(cif.cmd_ready), 1);
    chk("midrst_cardon", 32'(cardon), 0);
    chk("midrst_rgb", 32'(rgb), 0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    HCount = 10'd130; VCount = 10'd70;
    @(negedge clk);
    chk("refill1_cardon", 32'(cardon), 0);
    @(negedge clk);
    chk("refill2_cardon", 32'(cardon), 0);
    @(negedge clk);
    chk("refill3_pix", 32'({cardon, rgb}), 32'hC);
    #4;
    push_exp(275, 215, 4'b1100);
    push_exp(375, 215, 4'b1100);
    push_model(575, 415);
    drain();

    // Matched card: border and face image, flips ignored
    send_cmd(3, 0, 2);
    send_cmd(2, 0, 0);
    send_cmd(1, 0, 0);
    chk("busy_matched_flip", 32'(busy), 0);
    send_cmd(0, 0, 0);
    tick_clk();
    chk("busy_matched_flip2", 32'(busy), 0);
    do_tick();
    chk("busy_idle_tick", 32'(busy), 0);
    push_exp(130, 70, 4'b1010);
    push_exp(175, 115, {1'b1, rom_px(2, 45, 45)});
    push_exp(132, 115, 4'b1010);
    push_exp(134, 115, {1'b1, rom_px(2, 45, 4)});
    push_exp(219, 159, 4'b1010);
    drain();

    // Isolated pixel latency
    push_exp(0, 0, 4'b0000);
    push_exp(130, 70, 4'b1010);
    push_exp(0, 0, 4'b0000);
    push_exp(0, 0, 4'b0000);
    drain();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/card_grid_renderer.md
# card_grid_renderer

Parametrised renderer for the memory-game board: draws a ROWS×COLS grid of image cards on the 640×480 VGA raster. Each card has its own state (down, up, matched) and face index, and the block runs an animated flip between states. Commands come from the game controller over a valid/ready port. Pixel colour and coverage feed the VGA colour mux, and card images are read from an external synchronous card ROM.

## Interface
- ROWS, 4: grid rows.
- COLS, 4: grid columns; ROWS*COLS ≤ 64.
- ORIGIN_X, 130: left pixel of card (0,0).
- ORIGIN_Y, 70: top line of card (0,0).
- PITCH_X, 100: horizontal card-to-card stride.
- PITCH_Y, 100: vertical card-to-card stride.
- CARD_W, 90: card width in pixels; CARD_W ≤ PITCH_X.
- CARD_H, 90: card height in lines; CARD_H ≤ PITCH_Y, ≤ 128.
- FACE_W, 3: face-index width.
- ANIM_FRAMES, 8: flip duration in frames; even, ≥ 2.
- INSET_STEP, 10: horizontal inset added per animation phase; INSET_STEP*(ANIM_FRAMES/2) ≤ CARD_W/2.
- BORDER, 3: matched-card border thickness in pixels.
- IDX_W, 4: card-index width, clog2(ROWS*COLS).
- clk  in  1  pixel-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- HCount  in  10  current horizontal pixel.
- VCount  in  10  current vertical line.
- frame_tick  in  1  one-cycle pulse, once per frame.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 FLIP_UP, 01 FLIP_DOWN, 10 MATCH, 11 SET_FACE.
- cmd_idx  in  IDX_W  target card, row-major.
- cmd_face  in  FACE_W  face index for SET_FACE.
- busy  out  1  flip animation in progress.
- rom_face  out  FACE_W  ROM image select.
- rom_row  out  7  ROM image row.
- rom_data  in  3*CARD_W  ROM row, pixel c at bits [3c+2:3c]; valid one clock after rom_face/rom_row are registered.
- cardon  out  1  current pixel lies on a visible card.
- rgb  out  3  pixel colour when cardon = 1, else 0.

## Operation
- Per-card registers:
  - state: DOWN, UP or MATCHED.
  - face: FACE_W bits.
  - Reset: all cards DOWN, face 0.
- Commands:
  - A command is accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = !busy.
  - cmd_idx ≥ ROWS*COLS: accepted and ignored.
- SET_FACE: writes face; allowed in any state; no animation.
- FLIP_UP on a DOWN card, or FLIP_DOWN on an UP card:
  - Starts an animation on that card: anim_idx latched, phase = 0, busy = 1.
  - The target state is committed when the last phase ends.
- FLIP_UP on an UP card, FLIP_DOWN on a DOWN card, or any flip on a MATCHED card: accepted, no-op, busy stays 0.
- MATCH: sets state to MATCHED immediately, from any state.
- Animation:
  - phase increments on each frame_tick while busy.
  - On the frame_tick with phase = ANIM_FRAMES-1: state is updated, busy clears, phase returns to 0.
  - inset = INSET_STEP*min(phase, ANIM_FRAMES-1-phase).
  - Old side is shown for phase < ANIM_FRAMES/2; new side otherwise.
  - Pixels with local column < inset or ≥ CARD_W-inset are off-card (cardon = 0).
- Hit test:
  - Card (r,c) covers x in [ORIGIN_X+c*PITCH_X, +CARD_W-1] and y in [ORIGIN_Y+r*PITCH_Y, +CARD_H-1].
  - Found by per-row and per-column range compares; no dividers.
  - Gaps between cards and pixels outside the grid: cardon = 0, rgb = 0.
- Colour:
  - DOWN side: 3'b100.
  - UP side: rom_data pixel at local column, with rom_face = card face and rom_row = local line.
  - MATCHED: face image, except pixels within BORDER of any edge, which are 3'b010.

## Timing
- Reset values: cardon 0, rgb 0, rom_face 0, rom_row 0, busy 0, cmd_ready 1, phase 0.
- Free-running 3-stage pipeline:
  - Edge 1: HCount/VCount sampled; hit, card index, local column/line, state and inset side are registered; rom_face/rom_row are driven.
  - Edge 2: ROM data valid; stage-1 info is delayed.
  - Edge 3: cardon/rgb are registered.
- Outputs describe the pixel presented 3 clocks earlier; the VGA controller delays sync signals by 3.
- Card state and inset are sampled at stage 1, so a state change never tears within a pixel.
- Reset mid-animation: busy clears, all cards return to DOWN, faces return to 0.
- A command issued in the same cycle as the final frame_tick is refused, since cmd_ready is still 0; it is accepted on the next clock.
- A frame_tick while idle has no effect.

## Test plan
- Reset, then scan the full frame → cardon = 1 exactly on the 16 rectangles at x 130..219 / 230..319 / 330..419 / 430..519 and y 70..159 / 170..259 / 270..359 / 370..459; rgb = 3'b100 on them; 0 elsewhere, including gaps x = 220..229.
- SET_FACE idx 5 face 3, then FLIP_UP idx 5, then 8 frame_ticks:
  - busy is 1 until the 8th tick.
  - At phase 3, card 5 is on only for local columns 30..59 and is red.
  - At phase 4, columns 30..59 show ROM face 3 data.
  - After the flip, the full 90 columns show face 3.
- Command during the animation → cmd_ready = 0 and the card state is unchanged; the same command is accepted in the cycle after busy falls.
- MATCH idx 0, then FLIP_DOWN idx 0 → no animation, busy stays 0; pixel (130,70) = 3'b010; pixel (175,115) = ROM pixel 45 of line 45.
- Assert rst_n low during phase 2 → busy 0 and cmd_ready 1 immediately; all cards red; rgb/cardon 0 until the pipeline refills.
- Pipeline latency: drive HCount = 130, VCount = 70 for one clock in isolation → cardon rises exactly 3 clocks later.
